// File: rtl/req_ack_stream_responder_pkg.sv
// rtl/req_ack_stream_responder_pkg.sv - shared constants and width helper for the req/ack responder
package req_ack_stream_responder_pkg;

    localparam int ACK_PULSE_CYCLES   = 1;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 8;
    localparam int COUNT_WIDTH        = 32;

    // Bits needed to index 'value' entries; never returns less than 1.
    function automatic int clog2_width(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >>> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/req_ack_stream_responder_if.sv
// rtl/req_ack_stream_responder_if.sv - upstream stream, downstream req/ack and status bundle
interface req_ack_stream_responder_if
    import req_ack_stream_responder_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int depth      = DEFAULT_DEPTH
);
    localparam int addr_width = clog2_width(depth);

    logic                    in_valid;
    logic                    in_ready;
    logic [data_width-1:0]   in_data;
    logic                    req;
    logic                    ack;
    logic [data_width-1:0]   dout;
    logic [addr_width:0]     level;
    logic [COUNT_WIDTH-1:0]  count;

    modport master (
        output in_valid, in_data, req,
        input  in_ready, ack, dout, level, count
    );

    modport slave (
        input  in_valid, in_data, req,
        output in_ready, ack, dout, level, count
    );

endinterface

// File: rtl/req_ack_stream_responder_sync_fifo_core.sv
// rtl/req_ack_stream_responder_sync_fifo_core.sv - single-clock FIFO with occupancy counter
module sync_fifo_core
    import req_ack_stream_responder_pkg::*;
#(
    parameter  int data_width = DEFAULT_DATA_WIDTH,
    parameter  int depth      = DEFAULT_DEPTH,
    localparam int addr_width = clog2_width(depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [data_width-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [data_width-1:0] o_rd_data,
    output logic [addr_width:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam logic [addr_width:0] LEVEL_FULL = (addr_width+1)'(depth);

    logic [data_width-1:0] r_mem [depth];
    logic [addr_width-1:0] r_wr_ptr;
    logic [addr_width-1:0] r_rd_ptr;
    logic [addr_width:0]   r_level;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full  = (r_level == LEVEL_FULL);
    assign o_empty = (r_level == '0);
    assign w_wr    = i_wr_en & ~o_full;
    assign w_rd    = i_rd_en & ~o_empty;

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_level <= r_level + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule

// File: rtl/req_ack_stream_responder.sv
// rtl/req_ack_stream_responder.sv - pull-side responder: answers req with a one-cycle ack and registered data
module req_ack_stream_responder
    import req_ack_stream_responder_pkg::*;
#(
    parameter  int data_width = DEFAULT_DATA_WIDTH,
    parameter  int depth      = DEFAULT_DEPTH,
    localparam int addr_width = clog2_width(depth)
) (
    input  logic                        clk,
    input  logic                        rst,
    req_ack_stream_responder_if.slave   s
);
    logic [data_width-1:0]  w_rd_data;
    logic [addr_width:0]    w_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   r_ack;
    logic [data_width-1:0]  r_dout;
    logic [COUNT_WIDTH-1:0] r_count;

    assign w_push = s.in_valid & ~w_full;
    // Gating on the registered ack keeps acks at least two cycles apart even if req is held.
    assign w_pop  = s.req & ~r_ack & ~w_empty;

    sync_fifo_core #(
        .data_width (data_width),
        .depth      (depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_wr_en   (w_push),
        .i_wr_data (s.in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_dout  <= '0;
            r_count <= '0;
        end else begin
            r_ack <= w_pop;
            if (w_pop) begin
                r_dout  <= w_rd_data;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign s.in_ready = ~w_full;
    assign s.ack      = r_ack;
    assign s.dout     = r_dout;
    assign s.level    = w_level;
    assign s.count    = r_count;

endmodule

// File: tb/tb_req_ack_stream_responder.sv
// tb/tb_req_ack_stream_responder.sv - scoreboard bench for req_ack_stream_responder
module tb_req_ack_stream_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    req_ack_stream_responder_if #(.data_width(DW), .depth(DEPTH)) bus ();

    req_ack_stream_responder #(.data_width(DW), .depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, served count and expected-word scoreboard.
    logic [DW-1:0] exp_q[$];
    int            m_level;
    logic [31:0]   m_count;
    logic          m_ack;
    logic [DW-1:0] m_last;
    logic          prev_ack;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_level  = 0;
            m_count  = 0;
            m_ack    = 1'b0;
            m_last   = '0;
            prev_ack = 1'b0;
        end else begin
            if (bus.ack) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    m_last = exp_q.pop_front();
                end
            end
            chk("sb_dout", bus.dout, m_last);
            chk("ack_timing", bus.ack, m_ack);
            chk("ack_spacing", prev_ack & bus.ack, 1'b0);
            chk("level", bus.level, m_level);
            chk("count", bus.count, m_count);
            chk("in_ready", bus.in_ready, m_level != DEPTH);
            prev_ack = bus.ack;
            begin
                bit pop;
                bit push;
                pop  = bus.req && !m_ack && m_level > 0;
                push = bus.in_valid && m_level != DEPTH;
                m_ack = pop;
                if (pop) m_count = m_count + 1;
                if (push) exp_q.push_back(bus.in_data);
                m_level = m_level + int'(push) - int'(pop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int   guard;
        logic acc;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) break;
            guard++;
            if (guard > 300) begin
                chk("push_timeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ack();
        int guard;
        guard = 0;
        while (bus.ack !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        bus.req = 1'b1;
        while (bus.level != 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 64'd0, 64'd1);
        tick();
        tick();
        bus.req = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.req      = 1'b0;
        rst          = 1'b0;

        // Reset then idle
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_ack", bus.ack, 1'b0);
        chk("idle_dout", bus.dout, 0);
        chk("idle_level", bus.level, 0);
        chk("idle_count", bus.count, 0);
        chk("idle_in_ready", bus.in_ready, 1'b1);

        // Single word with req already high
        bus.req = 1'b1;
        push(32'h2A);
        tick();
        chk("single_ack", bus.ack, 1'b1);
        chk("single_dout", bus.dout, 32'h2A);
        chk("single_count", bus.count, 1);
        chk("single_level", bus.level, 0);
        tick();
        chk("single_ack_low", bus.ack, 1'b0);
        bus.req = 1'b0;

        // Burst with req held continuously
        bus.req = 1'b1;
        for (int i = 1; i <= 5; i++) push(i);
        repeat (12) tick();
        bus.req = 1'b0;
        chk("burst_count", bus.count, 6);

        // Fill past full, then a single pull frees one slot
        fork
            begin
                for (int i = 0; i < 10; i++) push(i);
            end
            begin
                repeat (14) tick();
                chk("full_level", bus.level, DEPTH);
                chk("full_in_ready", bus.in_ready, 1'b0);
                bus.req = 1'b1;
                tick();
                bus.req = 1'b0;
                chk("full_pop_ack", bus.ack, 1'b1);
                chk("full_pop_dout", bus.dout, 0);
                chk("full_pop_in_ready", bus.in_ready, 1'b1);
                tick();
                chk("full_refill_level", bus.level, DEPTH);
                chk("full_word9_waits", bus.in_ready, 1'b0);
                repeat (2) tick();
                drain();
            end
        join
        drain();

        // Level 3 then randomised concurrent push/pull through several pointer wraps
        for (int i = 0; i < 3; i++) push(32'h100 + i);
        for (int i = 0; i < 40; i++) begin
            bus.req = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 2)) tick();
            push($urandom);
        end
        drain();

        // Reset mid-operation while an ack is on the wire
        for (int i = 0; i < 5; i++) push(32'hA0 + i);
        bus.req = 1'b1;
        wait_ack();
        bus.req = 1'b0;
        chk("mid_level_before", bus.level, 4);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ack_killed", bus.ack, 1'b0);
        chk("async_level", bus.level, 0);
        chk("async_count", bus.count, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bus.req = 1'b1;
        push(32'h55);
        wait_ack();
        chk("post_reset_dout", bus.dout, 32'h55);
        chk("post_reset_count", bus.count, 1);
        bus.req = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_stream_responder.md
Name: req_ack_stream_responder

Overview:
- Synthesizable responder (data-source) end of the pull-style req/ack dataflow handshake used between async operators: downstream raises req, this block answers with a one-cycle ack pulse plus registered data.
- Upstream side is a push-style valid/ready stream into an internal FIFO.
- Replaces the behavioural producer model at array inputs.
- Lets the dataflow array be fed from real hardware (DMA, host bridge).

Parameters:
- data_width, 32, width of data words.
- depth, 8, FIFO entries; power of two, >= 2.
- addr_width, $clog2(depth), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream word present.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  data_width  upstream word.
- req  input  1  downstream request (pull).
- ack  output  1  one-cycle acknowledge pulse; dout valid in the same cycle.
- dout  output  data_width  served word, registered.
- level  output  addr_width+1  current FIFO occupancy, 0..depth.
- count  output  32  total words served since reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - ack=0, dout=0, count=0, level=0.
  - Read and write pointers cleared; FIFO empty.
  - in_ready=1 once rst deasserts.
- Write side:
  - in_ready = (level != depth), combinational from registered level.
  - A word is written when in_valid & in_ready at the clock edge.
  - No write when full. Upstream must hold in_valid and in_data until accepted.
- Read/ack rule, evaluated each edge:
  - Default: ack<=0.
  - If req & ~ack & (level != 0): ack<=1, dout<=fifo[rd_ptr], rd_ptr++, count++.
  - ack is never high two consecutive cycles; minimum spacing between acks is 2 cycles.
  - dout holds its last served value until the next ack.
- Latency:
  - Word written at edge t can be served at edge t+1 at the earliest (no write-to-read bypass).
  - With the FIFO non-empty and req already high, ack rises on the next edge.
- Empty with req high: no ack; req stays pending until data arrives, then normal ack.
- Simultaneous push and pop:
  - level unchanged.
  - When full, in_ready=0 that cycle, so no push. The pop frees a slot and in_ready rises the following cycle.
- Pointer wrap: pointers are addr_width bits and wrap modulo depth. level is tracked by a separate counter: +1 on push, -1 on pop, unchanged on both or neither.
- count wraps modulo 2^32.
- Reset mid-transfer: an ack pulse in flight is killed immediately (ack=0 asynchronously). Buffered data is discarded.
- Downstream contract: the consumer drops req in the cycle after it sees ack. This block does not require that; the ~ack gate alone prevents double service.

Decomposition:
- Shared package:
  - handshake constants: ACK_PULSE_CYCLES=1.
  - a $clog2-style width function, if the codebase does not already provide one.
  - default data_width.
- One natural sub-module: sync_fifo_core (storage array, pointers, level counter, full/empty flags).
- Responder FSM-free control lives in the top: ack gating, dout register, count.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, no stimulus -> ack=0, dout=0, level=0, count=0, in_ready=1.
- Single word: push 0x2A at edge t with req already high -> ack=1 at t+1 with dout=0x2A, count=1, level=0; ack=0 at t+2.
- Burst with req held high continuously: push 1..5 back-to-back -> acks every other cycle with dout 1,2,3,4,5 in order; never two consecutive ack cycles; count=5.
- Fill and full: depth=8, req=0, push 10 words 0..9 -> first 8 accepted, in_ready=0 with level=8. Then a single req -> dout=0 and in_ready=1 next cycle; word 8 accepted; 9 waits.
- Simultaneous push/pop at level 3: in_valid and req active in the same cycle -> level stays 3, ack issued, FIFO order preserved across pointer wrap (run 20 words through depth 8).
- Reset mid-operation: assert rst asynchronously while ack=1 and level=4 -> ack falls without a clock edge, level=0, count=0. After release, a new push of 0x55 is served first.
